// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier FSM states, radix-4 Booth digit codes
// and the digit-count helper used to size the sequencer.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    DIG_ZERO = 3'd0,
    DIG_P1   = 3'd1,
    DIG_P2   = 3'd2,
    DIG_M1   = 3'd3,
    DIG_M2   = 3'd4
  } booth_digit_e;

  // Operands are extended by two bits, so one extra digit covers the sign/zero pad.
  function automatic int booth_digit_count(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder: multiplier bit triplet {q[2i+1], q[2i], q[2i-1]}
// to a {zero, double, negate} control triple for the partial-sum adder.
module booth_r4_encoder
  import alu_pkg::*;
(
  input  logic [2:0] triplet,
  output logic       zero,
  output logic       double_m,
  output logic       negate
);

  booth_digit_e digit;

  always_comb begin
    digit = DIG_ZERO;
    case (triplet)
      3'b001, 3'b010: digit = DIG_P1;
      3'b011:         digit = DIG_P2;
      3'b100:         digit = DIG_M2;
      3'b101, 3'b110: digit = DIG_M1;
      default:        digit = DIG_ZERO;
    endcase
  end

  // negate stays low for the zero digit so the adder carry-in is never spurious
  assign zero     = (digit == DIG_ZERO);
  assign double_m = (digit == DIG_P2) || (digit == DIG_M2);
  assign negate   = (digit == DIG_M1) || (digit == DIG_M2);

endmodule

// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 Booth multiplier: one digit per cycle, signed or unsigned
// operands per operation, back-to-back start accepted in the DONE cycle.
module booth_radix4_multiplier
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     M,
  input  logic [WIDTH-1:0]     Q,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy,
  output logic                 done
);

  localparam int N    = booth_digit_count(WIDTH);
  localparam int EXT  = WIDTH + 2;
  localparam int ACCW = WIDTH + 3;
  localparam int CW   = $clog2(N + 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [EXT-1:0]       mcand_q, mcand_d;
  logic [EXT-1:0]       mplier_q, mplier_d;
  logic                 qm1_q, qm1_d;
  logic [ACCW-1:0]      acc_q, acc_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic                 dig_zero, dig_double, dig_negate;
  logic [ACCW-1:0]      addend_mag, addend, sum;
  logic [ACCW-1:0]      acc_shift;
  logic [EXT-1:0]       mplier_shift;
  logic [2*WIDTH-1:0]   product_final;
  logic [EXT-1:0]       m_ext, q_ext;
  logic                 accept, last_digit;

  booth_r4_encoder u_encoder (
    .triplet  ({mplier_q[1:0], qm1_q}),
    .zero     (dig_zero),
    .double_m (dig_double),
    .negate   (dig_negate)
  );

  assign m_ext = is_signed ? {{2{M[WIDTH-1]}}, M} : {2'b00, M};
  assign q_ext = is_signed ? {{2{Q[WIDTH-1]}}, Q} : {2'b00, Q};

  // Two's-complement subtract: invert the addend and feed negate in as carry.
  assign addend_mag = dig_double ? {mcand_q, 1'b0} : {mcand_q[EXT-1], mcand_q};
  assign addend     = dig_zero ? '0 : (dig_negate ? ~addend_mag : addend_mag);
  assign sum        = acc_q + addend + ACCW'(dig_negate);

  assign acc_shift     = {{2{sum[ACCW-1]}}, sum[ACCW-1:2]};
  assign mplier_shift  = {sum[1:0], mplier_q[EXT-1:2]};
  // After N shifts the multiplier register holds the low EXT product bits.
  assign product_final = {acc_shift[WIDTH-3:0], mplier_shift};

  assign accept     = start && (state_q != ST_CALC);
  assign last_digit = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    qm1_d    = qm1_q;
    acc_d    = acc_q;
    result_d = result_q;

    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_CALC: begin
        acc_d    = acc_shift;
        mplier_d = mplier_shift;
        qm1_d    = mplier_q[1];
        cnt_d    = cnt_q + CW'(1);
        if (last_digit) begin
          state_d  = ST_DONE;
          result_d = product_final;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      state_d  = ST_CALC;
      cnt_d    = '0;
      mcand_d  = m_ext;
      mplier_d = q_ext;
      qm1_d    = 1'b0;
      acc_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      qm1_q    <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      qm1_q    <= qm1_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;
  assign busy   = (state_q == ST_CALC);
  assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Directed bench for booth_radix4_multiplier: a 32-bit instance for the
// main scenarios and an 8-bit instance swept over corner operand values.
module tb_booth_radix4_multiplier;

  logic        clk;
  logic        rst;

  logic        start32, sgn32;
  logic [31:0] m32, q32;
  logic [63:0] res32;
  logic        busy32, done32;

  logic        start8, sgn8;
  logic [7:0]  m8, q8;
  logic [15:0] res8;
  logic        busy8, done8;

  int n_checks;
  int n_fail;

  booth_radix4_multiplier #(.WIDTH(32)) u_dut32 (
    .clk       (clk),
    .rst       (rst),
    .start     (start32),
    .is_signed (sgn32),
    .M         (m32),
    .Q         (q32),
    .result    (res32),
    .busy      (busy32),
    .done      (done32)
  );

  booth_radix4_multiplier #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .start     (start8),
    .is_signed (sgn8),
    .M         (m8),
    .Q         (q8),
    .result    (res8),
    .busy      (busy8),
    .done      (done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Issue one 32-bit op, wait for done (bounded), check latency and product.
  task automatic run32(input string tag, input logic sgn, input logic [31:0] m, input logic [31:0] q,
                       input logic [63:0] exp_res);
    int cycles;
    @(negedge clk);
    sgn32 = sgn; m32 = m; q32 = q; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    cycles = 0;
    while (!done32 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    check_value({tag, "_latency"}, 64'(cycles), 64'd17);
    check_value({tag, "_result"}, res32, exp_res);
    $display("op32 %s sgn=%0b M=0x%08h Q=0x%08h -> 0x%016h after %0d cycles", tag, sgn, m, q, res32, cycles);
  endtask

  task automatic run8(input logic sgn, input logic [7:0] m, input logic [7:0] q);
    int cycles;
    int a, b, p;
    logic [15:0] exp_res;
    a = sgn ? int'($signed(m)) : int'(m);
    b = sgn ? int'($signed(q)) : int'(q);
    p = a * b;
    exp_res = p[15:0];
    @(negedge clk);
    sgn8 = sgn; m8 = m; q8 = q; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    cycles = 0;
    while (!done8 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    check_value($sformatf("w8_lat_s%0b_%02h_%02h", sgn, m, q), 64'(cycles), 64'd5);
    check_value($sformatf("w8_res_s%0b_%02h_%02h", sgn, m, q), 64'(res8), 64'(exp_res));
    $display("op8 sgn=%0b M=0x%02h Q=0x%02h -> 0x%04h after %0d cycles", sgn, m, q, res8, cycles);
  endtask

  initial begin
    logic [7:0] vals8 [12];
    int cycles;
    int pulses;

    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    start32 = 1'b0; sgn32 = 1'b0; m32 = '0; q32 = '0;
    start8  = 1'b0; sgn8  = 1'b0; m8  = '0; q8  = '0;

    repeat (3) @(negedge clk);
    check_value("reset_result", res32, 64'd0);
    check_value("reset_busy", 64'(busy32), 64'd0);
    check_value("reset_done", 64'(done32), 64'd0);
    rst = 1'b1;

    // Scenario 1 plus one-cycle done pulse and result hold
    run32("s_12345x6789", 1'b1, 32'd12345, 32'd6789, 64'd83810205);
    check_value("s1_busy_in_done", 64'(busy32), 64'd0);
    @(negedge clk);
    check_value("s1_done_pulse_width", 64'(done32), 64'd0);
    check_value("s1_result_held", res32, 64'd83810205);

    run32("u_ffxff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run32("s_m1xm1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    run32("s_minxmin", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run32("s_maxxm1", 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0001);
    run32("u_0x123456789", 1'b0, 32'd0, 32'd123456789, 64'd0);

    // start held through CALC with changing operands, then back-to-back in DONE
    @(negedge clk);
    sgn32 = 1'b1; m32 = 32'd1000; q32 = 32'd3000; start32 = 1'b1;
    @(negedge clk);
    cycles = 0;
    while (!done32 && cycles < 40) begin
      m32 = $urandom; q32 = $urandom;
      @(negedge clk);
      cycles++;
    end
    check_value("hold_latency", 64'(cycles), 64'd17);
    check_value("hold_result", res32, 64'd3000000);
    $display("op32 hold_start 1000x3000 -> 0x%016h after %0d cycles", res32, cycles);
    m32 = 32'd987654321; q32 = 32'd123456789; sgn32 = 1'b0;
    @(negedge clk);
    start32 = 1'b0;
    check_value("b2b_busy", 64'(busy32), 64'd1);
    check_value("b2b_result_unchanged", res32, 64'd3000000);
    cycles = 0;
    while (!done32 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    check_value("b2b_latency", 64'(cycles), 64'd17);
    check_value("b2b_result", res32, 64'd121932631112635269);
    $display("op32 b2b 987654321x123456789 -> %0d after %0d cycles", res32, cycles);

    // Reset mid-calculation
    @(negedge clk);
    sgn32 = 1'b0; m32 = 32'd55; q32 = 32'd77; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (7) @(negedge clk);
    check_value("midrst_busy_before", 64'(busy32), 64'd1);
    rst = 1'b0;
    #1;
    check_value("midrst_busy", 64'(busy32), 64'd0);
    check_value("midrst_done", 64'(done32), 64'd0);
    check_value("midrst_result", res32, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (done32) pulses++;
    end
    check_value("midrst_no_done", 64'(pulses), 64'd0);
    $display("reset mid-CALC: result=0x%0h done pulses after=%0d", res32, pulses);

    // 8-bit corner sweep, both signedness modes
    vals8 = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h55, 8'h7F,
              8'h80, 8'h81, 8'hAA, 8'hC3, 8'hFE, 8'hFF};
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 12; i++) begin
        for (int j = 0; j < 12; j++) begin
          run8(s[0], vals8[i], vals8[j]);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
